// File: rtl/mem_bus_responder.sv
// Byte-addressed memory slave for a CPU MAR/MDR bus: captures one request,
// inserts WAIT_STATES wait cycles, performs a byte or little-endian word access.
module mem_bus_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] abus,
    input  logic [15:0] dbus_in,
    input  logic        mrd,
    input  logic        mwr,
    input  logic        w_b,
    output logic [15:0] dbus_out,
    output logic        dbus_oe,
    output logic        rdy,
    output logic        err
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic              r_word;
    logic              r_is_rd;
    logic [7:0]        r_mem [DEPTH];

    logic [ADDR_W-1:0] w_addr_hi;
    logic              w_start;
    logic              w_illegal;
    logic              w_do_write;
    logic [15:0]       w_rdata;
    logic              w_unused_abus;

    // Upper byte of a word access wraps to the bottom of storage.
    assign w_addr_hi     = r_addr + ADDR_W'(1);
    assign w_start       = mrd ^ mwr;
    assign w_illegal     = mrd & mwr;
    assign w_do_write    = (r_state == ST_ACCESS) && !r_is_rd;
    assign w_rdata       = {(r_word ? r_mem[w_addr_hi] : 8'h00), r_mem[r_addr]};
    assign w_unused_abus = ^abus;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            rdy      <= 1'b0;
            err      <= 1'b0;
            dbus_oe  <= 1'b0;
            dbus_out <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_addr  <= abus[ADDR_W-1:0];
                        r_wdata <= dbus_in;
                        r_word  <= w_b;
                        r_is_rd <= mrd;
                        r_cnt   <= CNT_W'(WAIT_STATES);
                        r_state <= (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
                    end else if (w_illegal) begin
                        r_state <= ST_DONE;
                        rdy     <= 1'b1;
                        err     <= 1'b1;
                        dbus_oe <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    rdy     <= 1'b1;
                    dbus_oe <= r_is_rd;
                    if (r_is_rd) begin
                        dbus_out <= w_rdata;
                    end
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    // Held strobes keep us here so one handshake is one access.
                    if (!mrd && !mwr) begin
                        r_state <= ST_IDLE;
                        rdy     <= 1'b0;
                        err     <= 1'b0;
                        dbus_oe <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Storage has no reset; a reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (rst_n && w_do_write) begin
            r_mem[r_addr] <= r_wdata[7:0];
            if (r_word) begin
                r_mem[w_addr_hi] <= r_wdata[15:8];
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: two instances (WAIT_STATES 2 and 0) share the bus
// and are checked against a byte-array memory model, directed tables and random traffic.
module tb_mem_bus_responder;
    localparam int unsigned ADDR_W = 8;
    localparam int          WS     = 2;
    localparam int          BUDGET = 40;

    typedef struct {
        bit          rd;
        bit          wr;
        bit          wb;
        logic [15:0] addr;
        logic [15:0] data;
        bit          chk_d;
        logic [15:0] exp_d;
        bit          exp_err;
        bit          exp_oe;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] abus;
    logic [15:0] dbus_in;
    logic        mrd;
    logic        mwr;
    logic        w_b;
    logic [15:0] dout2, dout0;
    logic        oe2, oe0, rdy2, rdy0, err2, err0;

    mem_bus_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) u_dut (
        .clk(clk), .rst_n(rst_n), .abus(abus), .dbus_in(dbus_in),
        .mrd(mrd), .mwr(mwr), .w_b(w_b),
        .dbus_out(dout2), .dbus_oe(oe2), .rdy(rdy2), .err(err2)
    );

    mem_bus_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .rst_n(rst_n), .abus(abus), .dbus_in(dbus_in),
        .mrd(mrd), .mwr(mwr), .w_b(w_b),
        .dbus_out(dout0), .dbus_oe(oe0), .rdy(rdy0), .err(err0)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [7:0]  m0 [256];
    logic [7:0]  m2 [256];
    logic [15:0] exp_d0;
    logic [15:0] exp_d2;
    vec_t        tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic scramble();
        abus    = 16'($urandom);
        dbus_in = 16'($urandom);
        w_b     = 1'($urandom);
    endtask

    // One full handshake, starting at a negedge; returns what the WS=2 instance reported.
    task automatic do_txn(input bit rd, input bit wr, input bit wb, input logic [15:0] addr,
                          input logic [15:0] data, input bit abort, input int hold,
                          output logic [15:0] o_d, output logic o_err, output logic o_oe);
        logic [7:0]  a;
        logic [7:0]  a1;
        bit          bad;
        int          e;
        int          lat0;
        int          lat2;
        int          exp_lat2;
        int          exp_lat0;
        logic [15:0] s_d0 = 'x;
        logic        s_e0 = 1'bx;
        logic        s_o0 = 1'bx;
        o_d   = 'x;
        o_err = 1'bx;
        o_oe  = 1'bx;
        bad = rd && wr;
        a   = addr[7:0];
        a1  = a + 8'd1;
        if (!bad && rd) begin
            exp_d0 = {(wb ? m0[a1] : 8'h00), m0[a]};
            exp_d2 = {(wb ? m2[a1] : 8'h00), m2[a]};
        end else if (!bad) begin
            m0[a] = data[7:0];
            m2[a] = data[7:0];
            if (wb) begin
                m0[a1] = data[15:8];
                m2[a1] = data[15:8];
            end
        end
        // Edge counts include the capture edge.
        exp_lat2 = bad ? 1 : WS + 2;
        exp_lat0 = bad ? 1 : 2;

        mrd = rd; mwr = wr; w_b = wb; abus = addr; dbus_in = data;
        @(posedge clk);
        e = 1; lat0 = 0; lat2 = 0;
        for (int k = 0; k < BUDGET; k++) begin
            @(negedge clk);
            if (lat0 == 0 && rdy0) begin
                lat0 = e; s_d0 = dout0; s_e0 = err0; s_o0 = oe0;
            end
            if (lat2 == 0 && rdy2) begin
                lat2 = e; o_d = dout2; o_err = err2; o_oe = oe2;
            end
            if (lat2 != 0) break;
            if (abort) begin
                mrd = 1'b0; mwr = 1'b0;
            end
            scramble();
            @(posedge clk);
            e++;
        end
        chk("lat_ws2", 32'(lat2), 32'(exp_lat2));
        chk("lat_ws0", 32'(lat0), 32'(exp_lat0));
        chk("err_ws2", 32'(o_err), 32'(bad));
        chk("oe_ws2", 32'(o_oe), 32'(rd && !wr));
        chk("dout_ws2", 32'(o_d), 32'(exp_d2));
        chk("err_ws0", 32'(s_e0), 32'(bad));
        chk("oe_ws0", 32'(s_o0), 32'(rd && !wr));
        chk("dout_ws0", 32'(s_d0), 32'(exp_d0));
        if (!abort) begin
            for (int h = 0; h < hold; h++) begin
                scramble();
                @(negedge clk);
                chk("hold_rdy", 32'({rdy0, rdy2}), 32'(2'b11));
            end
        end
        mrd = 1'b0; mwr = 1'b0;
        @(negedge clk);
        chk("release", 32'({rdy0, err0, oe0, rdy2, err2, oe2}), 32'(0));
        chk("release_dout", 32'(dout2), 32'(exp_d2));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic        e_;
        logic        o_;
        logic [7:0]  old;
        int          op;
        bit          ab;

        tbl[0]  = '{1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 16'h0011, 16'hC35A, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b1, 16'h5AEF, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'h0011, 16'h0000, 1'b1, 16'h005A, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 16'h01FF, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h0034, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0012, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 16'h00FF, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 16'h0010, 16'hFFFF, 1'b1, 16'h1234, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b1, 16'h5AEF, 1'b0, 1'b1};

        rst_n = 1'b0; mrd = 1'b0; mwr = 1'b0; w_b = 1'b0; abus = '0; dbus_in = '0;
        exp_d0 = '0; exp_d2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_flags", 32'({rdy2, err2, oe2, rdy0, err0, oe0}), 32'(0));
        chk("rst_dout2", 32'(dout2), 32'(0));
        chk("rst_dout0", 32'(dout0), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Give every byte a known value.
        for (int i = 0; i < 128; i++)
            do_txn(1'b0, 1'b1, 1'b1, 16'(2 * i), 16'($urandom), 1'b0, 0, d, e_, o_);

        for (int i = 0; i < 11; i++) begin
            do_txn(tbl[i].rd, tbl[i].wr, tbl[i].wb, tbl[i].addr, tbl[i].data, 1'b0, i % 3, d, e_, o_);
            chk("tbl_err", 32'(e_), 32'(tbl[i].exp_err));
            chk("tbl_oe", 32'(o_), 32'(tbl[i].exp_oe));
            if (tbl[i].chk_d) chk("tbl_dout", 32'(d), 32'(tbl[i].exp_d));
        end

        // Reset on the ACCESS edge of the WS=2 instance discards its write.
        old = m2[8'h40];
        abus = 16'h0040; dbus_in = {8'h00, ~old}; w_b = 1'b0; mrd = 1'b0; mwr = 1'b1;
        @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_flags", 32'({rdy2, err2, oe2, rdy0, err0, oe0}), 32'(0));
        chk("rst_mid_dout2", 32'(dout2), 32'(0));
        chk("rst_mid_dout0", 32'(dout0), 32'(0));
        rst_n = 1'b1; mwr = 1'b0;
        m0[8'h40] = ~old;
        exp_d0 = '0; exp_d2 = '0;
        do_txn(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 0, d, e_, o_);
        chk("rst_keep", 32'(d), 32'({8'h00, old}));

        // Strobes held for ten cycles while the data bus churns: one access only.
        do_txn(1'b0, 1'b1, 1'b1, 16'h0020, 16'hA55A, 1'b0, 10, d, e_, o_);
        do_txn(1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0, 10, d, e_, o_);
        chk("one_write", 32'(d), 32'(16'hA55A));

        // Requester drops the strobe right after capture; the write still lands.
        do_txn(1'b0, 1'b1, 1'b1, 16'h00FF, 16'h6789, 1'b1, 0, d, e_, o_);
        do_txn(1'b1, 1'b0, 1'b1, 16'h00FF, 16'h0000, 1'b0, 0, d, e_, o_);
        chk("abort_write", 32'(d), 32'(16'h6789));

        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 9));
            ab = (op != 0) && ($urandom_range(0, 5) == 0);
            do_txn(op == 0 || op < 5, op == 0 || op >= 5, 1'($urandom), 16'($urandom),
                   16'($urandom), ab, int'($urandom_range(0, 3)), d, e_, o_);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: storage depth is 2**ADDR_W bytes.
REQ-002 SHALL have parameter WAIT_STATES, default 2, legal range 0..15: number of inserted wait cycles.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 abus  input  16  byte address driven by the CPU MAR.
REQ-006 dbus_in  input  16  write data driven by the CPU MDR.
REQ-007 mrd  input  1  read strobe, level.
REQ-008 mwr  input  1  write strobe, level.
REQ-009 w_b  input  1  access size: 1 = word (16-bit), 0 = byte.
REQ-010 dbus_out  output  16  read data.
REQ-011 dbus_oe  output  1  dbus_out is valid and may drive the data bus.
REQ-012 rdy  output  1  access complete.
REQ-013 err  output  1  illegal request (mrd and mwr both high).

Function
REQ-014 SHALL implement a four-state FSM: IDLE, WAIT, ACCESS, DONE.
REQ-015 In IDLE, when exactly one of mrd/mwr is high at a rising edge, SHALL do all of the following:
- capture abus[ADDR_W-1:0] as a, dbus_in, w_b, and the direction;
- load the wait counter with WAIT_STATES;
- go to WAIT, or go straight to ACCESS when WAIT_STATES = 0.
REQ-016 Address bits abus[15:ADDR_W] SHALL be ignored.
REQ-017 In WAIT, SHALL decrement the counter each cycle and go to ACCESS on the edge where the counter equals 1.
REQ-018 Inputs changing during WAIT/ACCESS SHALL NOT affect the captured request.
REQ-019 In ACCESS, SHALL perform the access in that single cycle, then enter DONE with rdy = 1.
- Net latency: rdy rises exactly WAIT_STATES + 2 rising edges after the capture edge.
REQ-020 Byte write SHALL set mem[a] = dbus_in[7:0]; no other location changes.
REQ-021 Word write SHALL set mem[a] = dbus_in[7:0] and mem[(a+1) mod 2**ADDR_W] = dbus_in[15:8] (little-endian, wraps at top of storage).
REQ-022 Byte read SHALL register dbus_out = {8'h00, mem[a]}.
REQ-023 Word read SHALL register dbus_out = {mem[(a+1) mod 2**ADDR_W], mem[a]}.
REQ-024 dbus_oe SHALL equal rdy AND (captured direction is read); it SHALL be 0 for writes and errors.
REQ-025 In DONE, rdy, dbus_out and dbus_oe SHALL hold until a rising edge sees mrd = 0 and mwr = 0.
- On that edge: go to IDLE, clear rdy, dbus_oe and err.
- The next request is accepted no earlier than the following edge.
REQ-026 In IDLE, mrd = mwr = 1 at an edge SHALL go directly to DONE with rdy = 1, err = 1, no memory access, and dbus_out unchanged.
REQ-027 Strobes held high through DONE SHALL NOT start a second access; each access requires strobes to return low.
REQ-028 A strobe dropped before rdy (abort by requester) SHALL NOT cancel the captured access.
- The access completes; DONE exits on the first edge with both strobes low.
REQ-029 Memory SHALL be written only in ACCESS for a write request; at most one write per handshake.

Reset
REQ-030 While rst_n = 0 at a rising edge, SHALL set state = IDLE, rdy = 0, err = 0, dbus_oe = 0, dbus_out = 16'h0000, wait counter = 0.
REQ-031 Reset asserted mid-operation (WAIT or ACCESS edge) SHALL take priority: any pending write is discarded and memory is not modified on that edge.
REQ-032 Storage contents SHALL NOT be initialised by reset.

Verification
REQ-033 WAIT_STATES = 2, word write abus = 16'h0010, dbus_in = 16'hBEEF, mwr held -> rdy rises 4 edges after capture with dbus_oe = 0; word read of 16'h0010 -> dbus_out = 16'hBEEF, dbus_oe = 1.
REQ-034 Byte write 8'h5A to 16'h0011 after REQ-033 -> word read of 16'h0010 returns 16'h5AEF; byte read of 16'h0011 returns 16'h005A.
REQ-035 ADDR_W = 8, word write 16'h1234 to abus = 16'h01FF -> mem[FF] = 8'h34, mem[00] = 8'h12; word read of 16'h00FF returns 16'h1234.
REQ-036 mrd = mwr = 1 in IDLE -> next edge rdy = 1, err = 1, memory unchanged; both dropped -> rdy = err = 0 one edge later.
REQ-037 Write request, rst_n pulled low on the ACCESS edge -> target byte keeps its old value; all outputs 0; state IDLE.
REQ-038 WAIT_STATES = 0, read with mrd held 10 cycles -> rdy rises 2 edges after capture, exactly one access, rdy stays high until mrd drops.
